// File: rtl/tcp_option_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tcp_option_seq_ctrl
// Purpose  : Buffers the TCP option words of one segment, replays them
//            gap-free into the option decoder and reports the captured flags.
// Revision : 1.0 - initial release
// ============================================================================

module tcp_option_seq_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] FILLER       = 32'h01010101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [31:0] dec_data,
  output logic        dec_reset,
  input  logic [8:0]  dec_option_av,
  input  logic [8:0]  dec_option_err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [8:0]  res_option_av,
  output logic [8:0]  res_option_err,
  output logic [3:0]  res_data_offset,
  output logic        res_hdr_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_OPT_LOAD  = 3'd2,
    S_RESET_DEC = 3'd3,
    S_REPLAY    = 3'd4,
    S_FLUSH     = 3'd5,
    S_REPORT    = 3'd6,
    S_DRAIN     = 3'd7
  } state_t;

  localparam logic [3:0] c_flush_last = 4'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  r_off;
  logic        r_hdr_err;
  logic        r_eop_seen;
  logic [8:0]  r_av;
  logic [8:0]  r_err;
  logic [31:0] r_buf [10];
  logic        w_in_state;
  logic        w_accept;
  logic        w_restart;
  logic [3:0]  w_last_opt;

  assign w_in_state = (r_state == S_IDLE) || (r_state == S_HDR) ||
                      (r_state == S_OPT_LOAD) || (r_state == S_DRAIN);
  assign in_ready   = w_in_state && !reset;
  assign w_accept   = in_valid && in_ready;
  assign w_restart  = w_accept && in_sop;
  // Index of the last option word: n - 1 = off - 6.
  assign w_last_opt = r_off - 4'd6;

  assign res_option_av   = r_av;
  assign res_option_err  = r_err;
  assign res_data_offset = r_off;
  assign res_hdr_err     = r_hdr_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    dec_reset   = 1'b0;
    dec_data    = FILLER;
    res_valid   = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_HDR: begin
        if (w_accept) begin
          if (r_cnt == 4'd4)
            w_state_nxt = (r_off > 4'd5 && !in_eop) ? S_OPT_LOAD : S_REPORT;
          else if (in_eop)
            w_state_nxt = S_REPORT;
        end
      end
      S_OPT_LOAD: begin
        if (w_accept) begin
          if (r_cnt == w_last_opt) w_state_nxt = S_RESET_DEC;
          else if (in_eop)         w_state_nxt = S_REPORT;
        end
      end
      S_RESET_DEC: begin
        dec_reset   = 1'b1;
        w_state_nxt = S_REPLAY;
      end
      S_REPLAY: begin
        dec_data = r_buf[r_cnt];
        if (r_cnt == w_last_opt) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_cnt == c_flush_last) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = r_eop_seen ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_accept && in_eop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new sop abandons whatever segment is in progress; only possible while accepting.
    if (w_restart) w_state_nxt = in_eop ? S_REPORT : S_HDR;
    if (reset) begin
      dec_reset = 1'b1;
      dec_data  = FILLER;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_off      <= 4'd0;
      r_hdr_err  <= 1'b0;
      r_eop_seen <= 1'b0;
      r_av       <= 9'd0;
      r_err      <= 9'd0;
    end else if (w_restart) begin
      r_cnt      <= 4'd1;
      r_off      <= 4'd0;
      r_av       <= 9'd0;
      r_err      <= 9'd0;
      r_hdr_err  <= in_eop;
      r_eop_seen <= in_eop;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            if (r_cnt == 4'd3) r_off <= in_data[31:28];
            if (r_cnt == 4'd4) begin
              r_cnt      <= 4'd0;
              r_eop_seen <= in_eop;
              if (r_off < 4'd5 || (r_off > 4'd5 && in_eop)) r_hdr_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              if (in_eop) begin
                r_hdr_err  <= 1'b1;
                r_eop_seen <= 1'b1;
              end
            end
          end
        end
        S_OPT_LOAD: begin
          if (w_accept) begin
            if (r_cnt == w_last_opt) begin
              r_cnt      <= 4'd0;
              r_eop_seen <= in_eop;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              if (in_eop) begin
                r_hdr_err  <= 1'b1;
                r_eop_seen <= 1'b1;
              end
            end
          end
        end
        S_REPLAY: r_cnt <= (r_cnt == w_last_opt) ? 4'd0 : r_cnt + 4'd1;
        S_FLUSH: begin
          if (r_cnt == c_flush_last) begin
            r_cnt <= 4'd0;
            r_av  <= dec_option_av;
            r_err <= dec_option_err;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_hdr_err  <= 1'b0;
            r_eop_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_OPT_LOAD && w_accept && !in_sop) r_buf[r_cnt] <= in_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_tcp_option_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcp_option_seq_ctrl
// Purpose  : Vector-table, hand-written and randomized segment checks.
// Revision : 1.0 - initial release
// ============================================================================

module tb_tcp_option_seq_ctrl;

  localparam int          F      = 2;
  localparam logic [31:0] FILLER = 32'h01010101;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [31:0] dec_data;
  logic        dec_reset;
  logic [8:0]  dec_option_av, dec_option_err;
  logic        res_valid, res_ready;
  logic [8:0]  res_option_av, res_option_err;
  logic [3:0]  res_data_offset;
  logic        res_hdr_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  tcp_option_seq_ctrl #(.FLUSH_CYCLES(F), .FILLER(FILLER)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .dec_data(dec_data), .dec_reset(dec_reset),
    .dec_option_av(dec_option_av), .dec_option_err(dec_option_err),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_option_av(res_option_av), .res_option_err(res_option_err),
    .res_data_offset(res_data_offset), .res_hdr_err(res_hdr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decoder stand-in: an order- and gap-sensitive hash of every word since dec_reset.
  function automatic logic [17:0] stub_next(input logic [17:0] a, input logic [31:0] d);
    return {a[16:0], a[17]} ^ d[17:0] ^ {4'd0, d[31:18]};
  endfunction

  logic [17:0] stub_acc;
  always @(posedge clk) begin
    if (dec_reset) stub_acc <= 18'd0;
    else           stub_acc <= stub_next(stub_acc, dec_data);
  end
  assign dec_option_av  = stub_acc[8:0];
  assign dec_option_err = stub_acc[17:9];

  typedef struct {
    int         off;
    int         npay;
    int         eop_word;  // -1: eop on the final word
    int         gapmode;   // 0 none, 1 every other cycle, 2 random
    bit         fixed;
    bit         exp_hdr_err;
    bit         exp_run;
    logic [3:0] exp_off;
  } vec_t;

  logic [31:0] fixed_opt [3] = '{32'h020405B4, 32'h01030307, 32'h04020101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] data, input bit sop, input bit eop,
                           input int gapmode, output int acc_cyc);
    int stalls;
    stalls = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int s = 0; s < stalls; s++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(negedge clk);
      chk("in_ready_stall", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_data = data; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    chk("in_ready_accept", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Expected outcome of a segment derived from the header/eop rules.
  function automatic vec_t model(input int off, input int npay, input int eop_word, input int gapmode);
    vec_t v;
    int hdr_len, last;
    hdr_len = (off > 5) ? off : 5;
    last    = (eop_word < 0) ? hdr_len + npay - 1 : eop_word;
    v.off = off; v.npay = npay; v.eop_word = eop_word; v.gapmode = gapmode; v.fixed = 1'b0;
    v.exp_hdr_err = (last < hdr_len - 1) || (off < 5);
    v.exp_run     = !v.exp_hdr_err && (off > 5);
    v.exp_off     = (last >= 3) ? 4'(off) : 4'd0;
    return v;
  endfunction

  task automatic run_seg(input vec_t v);
    logic [31:0] w[$];
    logic [31:0] word;
    logic [17:0] a;
    int hdr_len, n, total, last, d, t0, c, stall;
    hdr_len = (v.off > 5) ? v.off : 5;
    n       = (v.off > 5) ? v.off - 5 : 0;
    total   = hdr_len + v.npay;
    last    = (v.eop_word < 0) ? total - 1 : v.eop_word;
    d       = (last < hdr_len - 1) ? last : hdr_len - 1;
    for (int i = 0; i < total; i++) begin
      word = $urandom;
      if (i == 3) word[31:28] = 4'(v.off);
      if (v.fixed && i >= 5 && i < 8) word = fixed_opt[i-5];
      w.push_back(word);
    end
    a = 18'd0;
    if (v.exp_run) begin
      for (int k = 0; k < n; k++) a = stub_next(a, w[5+k]);
      for (int f = 0; f < F - 1; f++) a = stub_next(a, FILLER);
    end
    t0 = 0;
    for (int i = 0; i <= d; i++) begin
      send_word(w[i], i == 0, i == last, (i == 0) ? 0 : v.gapmode, c);
      if (i == 0) t0 = c;
    end
    @(negedge clk);
    if (v.exp_run) begin
      chk("dec_reset_pulse", {31'd0, dec_reset}, 32'd1);
      chk("dec_data_in_reset_dec", dec_data, FILLER);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (v.gapmode == 0) chk("dec_reset_cycle", 32'(cyc - t0), 32'(v.off));
      for (int k = 0; k < n; k++) begin
        step(); @(negedge clk);
        chk("replay_word", dec_data, w[5+k]);
        chk("replay_dec_reset", {31'd0, dec_reset}, 32'd0);
      end
      for (int f = 0; f < F; f++) begin
        step(); @(negedge clk);
        chk("flush_filler", dec_data, FILLER);
        chk("flush_res_valid", {31'd0, res_valid}, 32'd0);
      end
      step(); @(negedge clk);
    end else begin
      chk("no_dec_reset", {31'd0, dec_reset}, 32'd0);
    end
    chk("res_valid_rise", {31'd0, res_valid}, 32'd1);
    if (v.gapmode == 0)
      chk("res_valid_cycle", 32'(cyc - t0), v.exp_run ? 32'(v.off + n + F + 1) : 32'(d + 1));
    chk("res_hdr_err", {31'd0, res_hdr_err}, {31'd0, v.exp_hdr_err});
    chk("res_data_offset", {28'd0, res_data_offset}, {28'd0, v.exp_off});
    chk("res_option_av", {23'd0, res_option_av}, {23'd0, a[8:0]});
    chk("res_option_err", {23'd0, res_option_err}, {23'd0, a[17:9]});
    stall = $urandom_range(0, 2);
    for (int s = 0; s < stall; s++) begin
      step(); @(negedge clk);
      chk("res_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("res_hold_av", {23'd0, res_option_av}, {23'd0, a[8:0]});
    end
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_fall", {31'd0, res_valid}, 32'd0);
    chk("hdr_err_cleared", {31'd0, res_hdr_err}, 32'd0);
    step();
    for (int i = d + 1; i <= last; i++) send_word(w[i], 1'b0, i == last, v.gapmode, c);
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_res_valid", {31'd0, res_valid}, 32'd0);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   c, off, npay, total, eop_word;
    logic [31:0] word;

    //          off npay eop gap fixed err run off
    tbl[0] = '{8,  0, -1, 0, 1'b1, 1'b0, 1'b1, 4'd8};
    tbl[1] = '{5,  2, -1, 0, 1'b0, 1'b0, 1'b0, 4'd5};
    tbl[2] = '{3,  2, -1, 0, 1'b0, 1'b1, 1'b0, 4'd3};
    tbl[3] = '{8,  1,  2, 0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[4] = '{15, 0, -1, 1, 1'b0, 1'b0, 1'b1, 4'd15};
    tbl[5] = '{6,  3, -1, 2, 1'b0, 1'b0, 1'b1, 4'd6};
    tbl[6] = '{9,  0,  6, 0, 1'b0, 1'b1, 1'b0, 4'd9};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; res_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("rst_dec_data", dec_data, FILLER);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_dec_reset", {31'd0, dec_reset}, 32'd0);
    chk("post_rst_res_fields", {res_option_av, res_option_err, res_data_offset, res_hdr_err}, 32'd0);
    step();

    for (int i = 0; i < 7; i++) run_seg(tbl[i]);

    // Stray non-sop word in IDLE is dropped; sop inside a header restarts the segment.
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 0, c);
    send_word(32'h11111111, 1'b1, 1'b0, 0, c);
    send_word(32'h22222222, 1'b0, 1'b0, 0, c);
    run_seg(tbl[0]);

    // Reset in the middle of a replay.
    for (int i = 0; i < 10; i++) begin
      word = $urandom;
      if (i == 3) word[31:28] = 4'd10;
      send_word(word, i == 0, i == 9, 0, c);
    end
    @(negedge clk);
    chk("mid_dec_reset", {31'd0, dec_reset}, 32'd1);
    step(); step();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("mid_rst_dec_data", dec_data, FILLER);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_post_dec_reset", {31'd0, dec_reset}, 32'd0);
    chk("mid_post_res_valid", {31'd0, res_valid}, 32'd0);
    step();
    run_seg(tbl[5]);

    for (int r = 0; r < 40; r++) begin
      off      = int'($urandom_range(0, 15));
      npay     = int'($urandom_range(0, 3));
      total    = ((off > 5) ? off : 5) + npay;
      eop_word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      v = model(off, npay, eop_word, int'($urandom_range(0, 2)));
      run_seg(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcp_option_seq_ctrl.md
# tcp_option_seq_ctrl

Sequences the TCP option decoder for one segment at a time. Accepts the TCP header as a 32-bit word stream and buffers the option words (up to 10). It then resets the decoder and replays the buffered words back-to-back, because the decoder counts bytes per clock and cannot tolerate gaps. After a flush period it captures the decoder flags and presents them through a valid/ready result handshake. It sits between the segment receive stream and the option decoder instance.

## Interface
Parameters:
- FLUSH_CYCLES, 2: filler cycles between the last replayed word and result capture (1..7).
- FILLER, 32'h01010101: word driven to the decoder when it is not replaying (four NOP bytes).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_data  input  32  header/payload word, first byte in [31:24]
- in_valid  input  1  in_data valid
- in_sop  input  1  first word of segment
- in_eop  input  1  last word of segment
- in_ready  output  1  word accepted when in_valid && in_ready
- dec_data  output  32  decoder data input
- dec_reset  output  1  decoder reset
- dec_option_av  input  9  decoder option_av
- dec_option_err  input  9  decoder option_err
- res_valid  output  1  result available
- res_ready  input  1  result consumed
- res_option_av  output  9  captured option_av
- res_option_err  output  9  captured option_err
- res_data_offset  output  4  data offset of the segment
- res_hdr_err  output  1  malformed header

## Operation
- States: IDLE, HDR, OPT_LOAD, RESET_DEC, REPLAY, FLUSH, REPORT, DRAIN.
- in_ready = 1 in IDLE, HDR, OPT_LOAD and DRAIN; 0 otherwise.
- IDLE:
  - An accepted word with in_sop is header word 0; go to HDR with word count 1.
  - Accepted words without in_sop are dropped.
- HDR:
  - Accepts words 1..4.
  - Word 3 bits [31:28] latch into data offset `off`.
  - When word 4 is accepted:
    - off < 5: set hdr_err and go to REPORT with av/err = 0.
    - off == 5: go to REPORT with av/err = 0; the decoder is not run.
    - otherwise: go to OPT_LOAD expecting n = off − 5 words (1..10).
- OPT_LOAD:
  - Writes accepted words into a 10×32 buffer at index 0..n−1.
  - When word n−1 is accepted, go to RESET_DEC.
- in_eop accepted in HDR or OPT_LOAD before the header is complete: set hdr_err, go to REPORT, set eop_seen.
- in_eop on the last header/option word: set eop_seen. No payload is expected after it.
- RESET_DEC: one cycle with dec_reset = 1 and dec_data = FILLER.
- REPLAY: n cycles with dec_data = buf[0..n−1] in order, dec_reset = 0.
- FLUSH: FLUSH_CYCLES cycles with dec_data = FILLER. On the last FLUSH edge, register dec_option_av and dec_option_err into res_*. Then go to REPORT.
- REPORT:
  - res_valid = 1 and all res_* are held stable.
  - On res_valid && res_ready: go to IDLE if eop_seen, else DRAIN.
  - Clear eop_seen and hdr_err on leaving REPORT.
- DRAIN: accepts and discards words until in_eop is accepted, then goes to IDLE.
- in_sop accepted in HDR, OPT_LOAD or DRAIN: abandon the current segment without reporting and restart at word 0 (go to HDR).
- dec_data = FILLER and dec_reset = 0 in all states other than RESET_DEC and REPLAY.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 0 during reset, 1 on the first cycle after reset
  - dec_reset = 1 during reset
  - dec_data = FILLER
  - res_valid = 0, res_* = 0, eop_seen = 0
- With in_valid held high, word k (sop = k = 0) is accepted at cycle k.
  - Last option word accepted at cycle off−1.
  - RESET_DEC at cycle off.
  - REPLAY at cycles off+1 .. off+n.
  - FLUSH at cycles off+n+1 .. off+n+FLUSH_CYCLES.
  - res_valid high from cycle off+n+FLUSH_CYCLES+1.
- off == 5 or hdr_err: res_valid rises the cycle after the accepting edge that decided it.
- res_valid stays high until the edge where res_ready = 1. It falls the next cycle, and the next state is entered on that same edge.
- Stalls (in_valid low) are allowed anywhere in HDR, OPT_LOAD and DRAIN. The replay itself is never stalled.

## Test plan
- off = 8, options MSS (02 04 05 B4), WS (01 03 03 07), SACK-perm (04 02 01 01), no payload (eop on word 7), FLUSH_CYCLES = 2, in_valid continuous:
  - dec_reset pulses at cycle 8.
  - dec_data carries the three words at cycles 9–11.
  - res_valid at cycle 14 with res_data_offset = 8 and the MSS/WS/SACK-perm bits set in res_option_av.
  - Returns to IDLE after res_ready.
- off = 5 with 2 payload words:
  - res_valid the cycle after word 4, av = 0, hdr_err = 0, dec_reset never pulses.
  - After res_ready, DRAIN consumes both payload words, eop returns to IDLE.
- off = 3: res_hdr_err = 1, av = 0; the payload is drained.
- in_eop on word 2:
  - res_hdr_err = 1.
  - After res_ready, goes directly to IDLE with no DRAIN.
- off = 15 with in_valid toggling every other cycle: all 10 buffered words are replayed on 10 consecutive cycles without gaps.
- Reset asserted during REPLAY: the next cycle is IDLE with dec_reset = 1 during reset and res_valid = 0. A following segment decodes correctly.
